// File: rtl/fifo_pkg.sv
// Shared constants and Gray-code helpers for the write- and read-side pointer blocks.
package fifo_pkg;

  localparam int FIFO_ADDR_WIDTH = 3;
  localparam int FIFO_DATA_WIDTH = 4;
  localparam int PTR_W           = FIFO_ADDR_WIDTH + 1;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Callers zero-extend narrower pointers; leading zeros leave the result unchanged.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for multi-bit Gray pointers crossing into i_clk.
module sync_2ff #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-domain pointer/flag stage of the dual-clock FIFO: address, write enable,
// Gray write pointer, registered full, almost-full, fill level and sticky overflow.
module fifo_wptr_full
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
  parameter int AF_MARGIN  = 2
) (
  input  logic                  wclk,
  input  logic                  rst_n,
  input  logic                  winc,
  input  logic                  wovf_clr,
  input  logic [ADDR_WIDTH:0]   rq_rptr,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic                  wen,
  output logic [ADDR_WIDTH:0]   wptr,
  output logic                  wfull,
  output logic                  walmost_full,
  output logic [ADDR_WIDTH:0]   wlevel,
  output logic                  woverflow
);

  localparam int PW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [PW-1:0] r_wbin;
  logic [PW-1:0] r_wptr;
  logic          r_wfull;
  logic          r_wovf;

  logic          w_wen;
  logic [PW-1:0] w_wbin_next;
  logic [PW-1:0] w_wgray_next;
  logic [PW-1:0] w_rq2_rptr;
  logic [PW-1:0] w_rq2_bin;
  logic [PW-1:0] w_full_cmp;
  logic [PW-1:0] w_level;
  logic [PW-1:0] w_free;

  sync_2ff #(.W(PW)) u_sync_rptr (
    .i_clk   (wclk),
    .i_rst_n (rst_n),
    .i_d     (rq_rptr),
    .o_q     (w_rq2_rptr)
  );

  // Binary bit i of a Gray value is the XOR of all Gray bits at or above i.
  genvar gi;
  generate
    for (gi = 0; gi < PW; gi++) begin : g_gray2bin
      assign w_rq2_bin[gi] = ^(w_rq2_rptr >> gi);
    end
  endgenerate

  assign w_wen        = winc & ~r_wfull;
  assign w_wbin_next  = r_wbin + {{(PW-1){1'b0}}, w_wen};
  assign w_wgray_next = w_wbin_next ^ (w_wbin_next >> 1);

  // Full when the writer is exactly one lap ahead: top two Gray bits inverted.
  assign w_full_cmp   = {~w_rq2_rptr[PW-1:PW-2], w_rq2_rptr[PW-3:0]};

  assign w_level      = r_wbin - w_rq2_bin;
  assign w_free       = PW'(DEPTH) - w_level;

  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      r_wbin  <= '0;
      r_wptr  <= '0;
      r_wfull <= 1'b0;
      r_wovf  <= 1'b0;
    end else begin
      r_wbin  <= w_wbin_next;
      r_wptr  <= w_wgray_next;
      r_wfull <= (w_wgray_next == w_full_cmp);
      if (winc && r_wfull) begin
        r_wovf <= 1'b1;
      end else if (wovf_clr) begin
        r_wovf <= 1'b0;
      end
    end
  end

  assign waddr        = r_wbin[ADDR_WIDTH-1:0];
  assign wen          = w_wen;
  assign wptr         = r_wptr;
  assign wfull        = r_wfull;
  assign wlevel       = w_level;
  assign walmost_full = (w_free <= PW'(AF_MARGIN));
  assign woverflow    = r_wovf;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Scoreboard bench for fifo_wptr_full: driver predicts each cycle from push/read counts,
// monitor compares the DUT against the queued predictions.
`timescale 1ns/1ps
module tb_fifo_wptr_full;

  localparam int DEPTH = 8;
  localparam int AF    = 2;

  logic       wclk = 1'b0;
  logic       rst_n;
  logic       winc;
  logic       wovf_clr;
  logic [3:0] rq_rptr;
  logic [2:0] waddr;
  logic       wen;
  logic [3:0] wptr;
  logic       wfull;
  logic       walmost_full;
  logic [3:0] wlevel;
  logic       woverflow;

  fifo_wptr_full #(.ADDR_WIDTH(3), .AF_MARGIN(AF)) dut (
    .wclk         (wclk),
    .rst_n        (rst_n),
    .winc         (winc),
    .wovf_clr     (wovf_clr),
    .rq_rptr      (rq_rptr),
    .waddr        (waddr),
    .wen          (wen),
    .wptr         (wptr),
    .wfull        (wfull),
    .walmost_full (walmost_full),
    .wlevel       (wlevel),
    .woverflow    (woverflow)
  );

  always #5 wclk = ~wclk;

  typedef struct {
    int wen;
    int waddr;
    int wptr;
    int full;
    int af;
    int level;
    int ovf;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Reference state: absolute counts, not wrapped pointers.
  int   m_wcount;
  bit   m_full;
  bit   m_ovf;
  int   rh[$];     // read count presented to the DUT at each edge since reset
  int   whist[$];  // push count at the start of each cycle, for the lagging reader

  function automatic logic [3:0] gray(input int n);
    logic [3:0] b;
    b = n[3:0];
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_wcount = 0;
    m_full   = 1'b0;
    m_ovf    = 1'b0;
    rh.delete();
    whist.delete();
  endtask

  task automatic cycle(input bit wi, input bit cl, input int rn);
    exp_t e;
    int   k, rb, ra;
    @(negedge wclk);
    winc     = wi;
    wovf_clr = cl;
    rq_rptr  = gray(rn);
    whist.push_back(m_wcount);
    e.wen   = (wi && !m_full) ? 1 : 0;
    e.waddr = m_wcount % DEPTH;
    rh.push_back(rn);
    k  = rh.size() - 1;
    rb = (k >= 2) ? rh[k-2] : 0;   // read count seen by full logic at this edge
    ra = (k >= 1) ? rh[k-1] : 0;   // read count visible after this edge
    if (wi && m_full) m_ovf = 1'b1;
    else if (cl)      m_ovf = 1'b0;
    m_wcount += e.wen;
    m_full  = ((m_wcount - rb) == DEPTH);
    e.wptr  = gray(m_wcount);
    e.full  = m_full;
    e.level = m_wcount - ra;
    e.af    = ((DEPTH - e.level) <= AF) ? 1 : 0;
    e.ovf   = m_ovf;
    sb.push_back(e);
    $display("cyc t=%0t winc=%0d clr=%0d rcnt=%0d -> wen=%0d waddr=%0d wptr=%0d full=%0d lvl=%0d ovf=%0d",
             $time, wi, cl, rn, e.wen, e.waddr, e.wptr, e.full, e.level, e.ovf);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_wptr"},  int'(wptr),         0);
    chk({tag, "_wfull"}, int'(wfull),        0);
    chk({tag, "_wlvl"},  int'(wlevel),       0);
    chk({tag, "_wovf"},  int'(woverflow),    0);
    chk({tag, "_waddr"}, int'(waddr),        0);
    chk({tag, "_wen"},   int'(wen),          0);
    chk({tag, "_af"},    int'(walmost_full), 0);
  endtask

  task automatic reset_pulse();
    @(posedge wclk);
    #2;
    rst_n    = 1'b0;
    winc     = 1'b0;
    wovf_clr = 1'b0;
    rq_rptr  = '0;
    #1;
    check_zero("rst_async");
    model_reset();
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: combinational outputs mid-low-phase, registered outputs just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge wclk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("wen",   int'(wen),   e.wen);
        chk("waddr", int'(waddr), e.waddr);
        @(posedge wclk);
        #1;
        chk("wptr",   int'(wptr),         e.wptr);
        chk("wfull",  int'(wfull),        e.full);
        chk("wlevel", int'(wlevel),       e.level);
        chk("walmf",  int'(walmost_full), e.af);
        chk("wovf",   int'(woverflow),    e.ovf);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int rn;
    int rc;
    rst_n    = 1'b0;
    winc     = 1'b0;
    wovf_clr = 1'b0;
    rq_rptr  = '0;
    model_reset();
    #12;
    rst_n = 1'b1;
    #1;
    check_zero("rst_init");

    // Fill from empty with a stalled reader.
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 0);
    // Push while full, then clear the sticky flag.
    cycle(1'b1, 1'b0, 0);
    cycle(1'b0, 1'b0, 0);
    cycle(1'b0, 1'b1, 0);
    cycle(1'b0, 1'b0, 0);
    // Reader frees one entry; full drops after the sync latency.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1);
    cycle(1'b1, 1'b0, 1);
    cycle(1'b0, 1'b0, 1);

    // Asynchronous reset mid-operation.
    reset_pulse();
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 0);
    reset_pulse();

    // Reader trails the writer by four cycles; pointer wraps past 15.
    rn = 0;
    for (int i = 0; i < 20; i++) begin
      rn = (whist.size() >= 4) ? whist[whist.size()-4] : 0;
      cycle(1'b1, 1'b0, rn);
    end
    // Stall the reader, overfill, clear, then set and clear together.
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, rn);
    cycle(1'b0, 1'b1, rn);
    cycle(1'b1, 1'b1, rn);
    cycle(1'b0, 1'b0, rn);

    // Random traffic with a reader that never overtakes the writer.
    rc = rn;
    for (int i = 0; i < 200; i++) begin
      if (($urandom_range(0, 1) == 1) && (rc < m_wcount)) rc++;
      cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0), rc);
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, rc);

    @(posedge wclk);
    #3;
    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
